// File: rtl/wb_arbiter.sv
// Writeback collector: three buffered result sources, round-robin onto the register-file write port, plus busy scoreboard.
// Optional: define WB_ZERO_REG_EN to suppress writes to and scoreboarding of general r0.
`timescale 1ns/1ps
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic        alu_gfflag,
  input  logic [3:0]  alu_num,
  input  logic [31:0] alu_data,
  input  logic        fpu_valid,
  output logic        fpu_ready,
  input  logic        fpu_gfflag,
  input  logic [3:0]  fpu_num,
  input  logic [31:0] fpu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_gfflag,
  input  logic [3:0]  lsu_num,
  input  logic [31:0] lsu_data,
  input  logic        iss_valid,
  input  logic        iss_gfflag,
  input  logic [3:0]  iss_num,
  output logic        rd_gfflag,
  output logic [3:0]  rd_num,
  output logic [31:0] rd_data,
  output logic        enable,
  output logic [31:0] busy,
  output logic        idle
);

  typedef struct packed {
    logic        gfflag;
    logic [3:0]  num;
    logic [31:0] data;
  } beat_t;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_FPU = 2'd1;
  localparam logic [1:0] SRC_LSU = 2'd2;

  logic [2:0] in_valid, push, pop, nonempty, nonempty_next, ready_vec;
  beat_t      in_beat [3];
  beat_t      head    [3];

  assign in_valid   = {lsu_valid, fpu_valid, alu_valid};
  assign in_beat[0] = {alu_gfflag, alu_num, alu_data};
  assign in_beat[1] = {fpu_gfflag, fpu_num, fpu_data};
  assign in_beat[2] = {lsu_gfflag, lsu_num, lsu_data};
  assign alu_ready  = ready_vec[0];
  assign fpu_ready  = ready_vec[1];
  assign lsu_ready  = ready_vec[2];

  for (genvar s = 0; s < 3; s++) begin : g_fifo
    beat_t          mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  cnt, cnt_next;
    logic           rdy;

    assign push[s]          = in_valid[s] & rdy;
    assign cnt_next         = cnt + CW'(push[s]) - CW'(pop[s]);
    assign nonempty[s]      = (cnt != '0);
    assign nonempty_next[s] = (cnt_next != '0);
    assign head[s]          = mem[rd_ptr];
    assign ready_vec[s]     = rdy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        rdy    <= 1'b1;
      end else begin
        if (push[s]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[s])  rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt_next;
        // Full stays not-ready through a popping cycle; ready returns one cycle later.
        rdy <= (cnt_next < CW'(FIFO_DEPTH));
      end
    end

    // NOTE: payload storage has no reset; emptiness is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
      if (push[s]) mem[wr_ptr] <= in_beat[s];
    end
  end

  logic [1:0]  rr_q, grant_src, c0, c1, c2;
  logic        grant_any, is_r0, write_ok;
  beat_t       gbeat;
  logic [31:0] set_mask, clr_mask;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_src = SRC_ALU;
    c0 = SRC_ALU;
    c1 = SRC_FPU;
    c2 = SRC_LSU;
    case (rr_q)
      SRC_ALU: begin c0 = SRC_FPU; c1 = SRC_LSU; c2 = SRC_ALU; end
      SRC_FPU: begin c0 = SRC_LSU; c1 = SRC_ALU; c2 = SRC_FPU; end
      default: begin c0 = SRC_ALU; c1 = SRC_FPU; c2 = SRC_LSU; end
    endcase
    if (nonempty[c0]) begin
      grant_any = 1'b1;
      grant_src = c0;
    end else if (nonempty[c1]) begin
      grant_any = 1'b1;
      grant_src = c1;
    end else if (nonempty[c2]) begin
      grant_any = 1'b1;
      grant_src = c2;
    end
  end

  assign gbeat    = head[grant_src];
  assign pop      = grant_any ? (3'b001 << grant_src) : 3'b000;
  assign clr_mask = grant_any ? (32'd1 << {gbeat.gfflag, gbeat.num}) : 32'd0;

`ifdef WB_ZERO_REG_EN
  assign is_r0    = ~gbeat.gfflag & (gbeat.num == 4'd0);
  assign set_mask = (iss_valid ? (32'd1 << {iss_gfflag, iss_num}) : 32'd0) & ~32'd1;
`else
  assign is_r0    = 1'b0;
  assign set_mask = iss_valid ? (32'd1 << {iss_gfflag, iss_num}) : 32'd0;
`endif

  assign write_ok = grant_any & ~is_r0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enable    <= 1'b0;
      rd_gfflag <= 1'b0;
      rd_num    <= 4'd0;
      rd_data   <= 32'd0;
      rr_q      <= SRC_LSU;
      busy      <= 32'd0;
      idle      <= 1'b1;
    end else begin
      enable <= write_ok;
      if (write_ok) begin
        rd_gfflag <= gbeat.gfflag;
        rd_num    <= gbeat.num;
        rd_data   <= gbeat.data;
      end
      if (grant_any) rr_q <= grant_src;
      // Set is applied after clear so a same-edge issue keeps the bit busy.
      busy <= (busy & ~clr_mask) | set_mask;
      idle <= ~|nonempty_next & ~write_ok;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: reset, latency, round-robin, backpressure, scoreboard, async reset, r0 option.
`timescale 1ns/1ps
module tb_wb_arbiter;

  logic        clk, rstn;
  logic        alu_valid, alu_gfflag, fpu_valid, fpu_gfflag, lsu_valid, lsu_gfflag;
  logic [3:0]  alu_num, fpu_num, lsu_num, iss_num;
  logic [31:0] alu_data, fpu_data, lsu_data;
  logic        iss_valid, iss_gfflag;
  logic        alu_ready, fpu_ready, lsu_ready;
  logic        rd_gfflag, enable, idle;
  logic [3:0]  rd_num;
  logic [31:0] rd_data, busy;

  int total = 0;
  int bad   = 0;

`ifdef WB_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_gfflag(alu_gfflag), .alu_num(alu_num), .alu_data(alu_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_gfflag(fpu_gfflag), .fpu_num(fpu_num), .fpu_data(fpu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_gfflag(lsu_gfflag), .lsu_num(lsu_num), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_gfflag(iss_gfflag), .iss_num(iss_num),
    .rd_gfflag(rd_gfflag), .rd_num(rd_num), .rd_data(rd_data),
    .enable(enable), .busy(busy), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] beat_data(input int src, input int idx);
    logic [31:0] base;
    base = (src == 0) ? 32'hA000_0000 : (src == 1) ? 32'hF000_0000 : 32'hC000_0000;
    return base | 32'(idx);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    alu_valid = 0; alu_gfflag = 0; alu_num = 0; alu_data = 0;
    fpu_valid = 0; fpu_gfflag = 0; fpu_num = 0; fpu_data = 0;
    lsu_valid = 0; lsu_gfflag = 0; lsu_num = 0; lsu_data = 0;
    iss_valid = 0; iss_gfflag = 0; iss_num = 0;
  endtask

  task automatic reset_dut;
    clear_inputs();
    rstn = 1'b0;
    #4;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    reset_dut();
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL reset_enable got=%b want=0", enable); end
    total++; if (rd_gfflag !== 1'b0) begin bad++; $display("FAIL reset_rd_gfflag got=%b want=0", rd_gfflag); end
    total++; if (rd_num !== 4'd0) begin bad++; $display("FAIL reset_rd_num got=%0d want=0", rd_num); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy); end
    total++; if ({lsu_ready, fpu_ready, alu_ready} !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b want=111", {lsu_ready, fpu_ready, alu_ready}); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle); end
  endtask

  task automatic test_single;
    reset_dut();
    iss_valid = 1; iss_gfflag = 0; iss_num = 4'd5;
    tick();
    iss_valid = 0;
    total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL single_busy_set got=%b want=1", busy[5]); end
    alu_valid = 1; alu_gfflag = 0; alu_num = 4'd5; alu_data = 32'hDEAD_BEEF;
    tick();
    alu_valid = 0;
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL single_enable_early got=%b want=0", enable); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_idle_queued got=%b want=0", idle); end
    total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL single_busy_held got=%b want=1", busy[5]); end
    tick();
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL single_enable got=%b want=1", enable); end
    total++; if ({rd_gfflag, rd_num} !== 5'd5) begin bad++; $display("FAIL single_rd_idx got=%0d want=5", {rd_gfflag, rd_num}); end
    total++; if (rd_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rd_data got=%h want=deadbeef", rd_data); end
    total++; if (busy[5] !== 1'b0) begin bad++; $display("FAIL single_busy_clear got=%b want=0", busy[5]); end
    tick();
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL single_enable_drop got=%b want=0", enable); end
    total++; if (rd_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rd_hold got=%h want=deadbeef", rd_data); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle_after got=%b want=1", idle); end
  endtask

  task automatic test_round_robin;
    int ai, fi, li, nw, first, last;
    logic a_acc, f_acc, l_acc;
    logic [36:0] exp_w;
    reset_dut();
    ai = 0; fi = 0; li = 0; nw = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      alu_valid = (ai < 3); alu_gfflag = 0; alu_num = 4'(ai + 1); alu_data = beat_data(0, ai);
      fpu_valid = (fi < 3); fpu_gfflag = 1; fpu_num = 4'(fi);     fpu_data = beat_data(1, fi);
      lsu_valid = (li < 3); lsu_gfflag = 0; lsu_num = 4'(8 + li); lsu_data = beat_data(2, li);
      a_acc = alu_valid & alu_ready;
      f_acc = fpu_valid & fpu_ready;
      l_acc = lsu_valid & lsu_ready;
      tick();
      if (a_acc) ai++;
      if (f_acc) fi++;
      if (l_acc) li++;
      if (enable) begin
        case (nw % 3)
          0:       exp_w = {1'b0, 4'(nw / 3 + 1), beat_data(0, nw / 3)};
          1:       exp_w = {1'b1, 4'(nw / 3),     beat_data(1, nw / 3)};
          default: exp_w = {1'b0, 4'(8 + nw / 3), beat_data(2, nw / 3)};
        endcase
        total++;
        if ({rd_gfflag, rd_num, rd_data} !== exp_w) begin
          bad++; $display("FAIL rr_write%0d got=%h want=%h", nw, {rd_gfflag, rd_num, rd_data}, exp_w);
        end
        nw++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    clear_inputs();
    total++; if (nw !== 9) begin bad++; $display("FAIL rr_write_count got=%0d want=9", nw); end
    total++; if (last - first !== 8) begin bad++; $display("FAIL rr_consecutive got=%0d want=8", last - first); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rr_idle got=%b want=1", idle); end
  endtask

  task automatic test_backpressure;
    int ai, fi, aw, fw;
    logic a_acc, f_acc;
    reset_dut();
    ai = 0; fi = 0; aw = 0; fw = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      alu_valid = (ai < 6); alu_gfflag = 0; alu_num = 4'd2; alu_data = beat_data(0, ai);
      fpu_valid = (fi < 3); fpu_gfflag = 1; fpu_num = 4'd4; fpu_data = beat_data(1, fi);
      a_acc = alu_valid & alu_ready;
      f_acc = fpu_valid & fpu_ready;
      tick();
      if (a_acc) ai++;
      if (f_acc) begin
        if (fi == 2) begin
          total++; if (fw < 1) begin bad++; $display("FAIL bp_third_accept_before_pop got=%0d want>=1", fw); end
        end
        fi++;
        if (fi == 2) begin
          total++; if (fpu_ready !== 1'b0) begin bad++; $display("FAIL bp_fpu_ready_full got=%b want=0", fpu_ready); end
        end
      end
      if (enable) begin
        if (rd_gfflag) begin
          total++; if (rd_data !== beat_data(1, fw)) begin bad++; $display("FAIL bp_fpu_order%0d got=%h want=%h", fw, rd_data, beat_data(1, fw)); end
          fw++;
        end else begin
          total++; if (rd_data !== beat_data(0, aw)) begin bad++; $display("FAIL bp_alu_order%0d got=%h want=%h", aw, rd_data, beat_data(0, aw)); end
          aw++;
        end
      end
    end
    clear_inputs();
    total++; if (fw !== 3) begin bad++; $display("FAIL bp_fpu_writes got=%0d want=3", fw); end
    total++; if (aw !== 6) begin bad++; $display("FAIL bp_alu_writes got=%0d want=6", aw); end
  endtask

  task automatic test_same_edge;
    reset_dut();
    iss_valid = 1; iss_gfflag = 1; iss_num = 4'd3;
    tick();
    iss_valid = 0;
    total++; if (busy[19] !== 1'b1) begin bad++; $display("FAIL same_busy_set got=%b want=1", busy[19]); end
    fpu_valid = 1; fpu_gfflag = 1; fpu_num = 4'd3; fpu_data = 32'h0000_0013;
    tick();
    fpu_valid = 0;
    iss_valid = 1; iss_gfflag = 1; iss_num = 4'd3;
    tick();
    iss_valid = 0;
    total++; if ({enable, rd_gfflag, rd_num} !== 6'b1_1_0011) begin bad++; $display("FAIL same_write got=%b want=110011", {enable, rd_gfflag, rd_num}); end
    total++; if (busy[19] !== 1'b1) begin bad++; $display("FAIL same_set_wins got=%b want=1", busy[19]); end
    tick();
    total++; if (busy !== 32'h0008_0000) begin bad++; $display("FAIL same_busy_after got=%h want=00080000", busy); end
  endtask

  task automatic test_reset_mid;
    int nen;
    reset_dut();
    iss_valid = 1; iss_gfflag = 0; iss_num = 4'd7;
    tick();
    iss_valid = 0;
    alu_valid = 1; alu_num = 4'd1; alu_data = 32'h1111_0001;
    fpu_valid = 1; fpu_gfflag = 1; fpu_num = 4'd2; fpu_data = 32'h2222_0002;
    tick();
    fpu_valid = 0;
    alu_data = 32'h1111_0003;
    tick();
    alu_valid = 0;
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL mid_pre_enable got=%b want=1", enable); end
    #2;
    rstn = 1'b0;
    #0.5;
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL mid_async_enable got=%b want=0", enable); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL mid_async_busy got=%h want=0", busy); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL mid_async_rd_data got=%h want=0", rd_data); end
    #0.5;
    rstn = 1'b1;
    nen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (enable) nen++;
    end
    total++; if (nen !== 0) begin bad++; $display("FAIL mid_discarded got=%0d want=0", nen); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL mid_idle got=%b want=1", idle); end
  endtask

  task automatic test_zero_reg;
    reset_dut();
    iss_valid = 1; iss_gfflag = 0; iss_num = 4'd0;
    tick();
    iss_valid = 0;
    total++; if (busy[0] !== !ZERO) begin bad++; $display("FAIL zero_busy_set got=%b want=%b", busy[0], !ZERO); end
    lsu_valid = 1; lsu_gfflag = 0; lsu_num = 4'd0; lsu_data = 32'h0000_1111;
    tick();
    lsu_valid = 0;
    alu_valid = 1; alu_gfflag = 0; alu_num = 4'd1; alu_data = 32'h0000_2222;
    tick();
    alu_valid = 0;
    total++; if (enable !== !ZERO) begin bad++; $display("FAIL zero_r0_enable got=%b want=%b", enable, !ZERO); end
    if (!ZERO) begin
      total++; if (rd_data !== 32'h0000_1111) begin bad++; $display("FAIL zero_r0_data got=%h want=00001111", rd_data); end
    end
    tick();
    total++; if ({enable, rd_gfflag, rd_num} !== 6'b1_0_0001) begin bad++; $display("FAIL zero_r1_write got=%b want=100001", {enable, rd_gfflag, rd_num}); end
    total++; if (rd_data !== 32'h0000_2222) begin bad++; $display("FAIL zero_r1_data got=%h want=00002222", rd_data); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL zero_busy_end got=%b want=0", busy[0]); end
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_same_edge();
    test_reset_mid();
    test_zero_reg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
